// File: rtl/mesh_term_fifo.sv
// Terminal-side ingress FIFO feeding one mesh router port: first-word fall-through,
// destination filtering, and sticky overflow/underflow reporting.
module mesh_term_fifo #(
  parameter int          pckg_sz    = 40,
  parameter int          fifo_depth = 4,
  parameter int          rows       = 4,
  parameter int          columns    = 4,
  parameter logic [7:0]  broadcast  = {8{1'b1}}
) (
  input  logic                              clk_i,
  input  logic                              reset,
  input  logic                              push,
  input  logic [pckg_sz-1:0]                data_in,
  output logic                              full,
  output logic [pckg_sz-1:0]                data_out_i_in,
  output logic                              pndng_i_in,
  input  logic                              popin,
  output logic [$clog2(fifo_depth+1)-1:0]   count,
  output logic [7:0]                        drop_cnt,
  output logic                              ovf,
  output logic                              udf
);

  localparam int cnt_w = $clog2(fifo_depth + 1);
  localparam int ptr_w = $clog2(fifo_depth);
  localparam logic [cnt_w-1:0] depth_c = cnt_w'(fifo_depth);
  localparam logic [ptr_w-1:0] last_c  = ptr_w'(fifo_depth - 1);

  logic [pckg_sz-1:0] mem [fifo_depth];
  logic [ptr_w-1:0]   rd_ptr, wr_ptr;

  logic [7:0] jump;
  logic [3:0] row, col;
  logic       dest_ok;
  logic       pop_acc, push_acc;

  assign jump = data_in[pckg_sz-1  -: 8];
  assign row  = data_in[pckg_sz-9  -: 4];
  assign col  = data_in[pckg_sz-13 -: 4];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dest_ok = 1'b0;
    if (jump == broadcast)
      dest_ok = 1'b1;
    else if (int'(row) < rows && int'(col) < columns)
      dest_ok = 1'b1;
  end

  // A full FIFO still accepts a push when the router frees the head on the same edge.
  assign pop_acc  = popin && (count != '0);
  assign push_acc = push && dest_ok && ((count != depth_c) || pop_acc);

  function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
    return (p == last_c) ? '0 : p + ptr_w'(1);
  endfunction

  // NOTE: the storage array is not reset; stale entries are never visible because the head is masked when empty.
  always_ff @(posedge clk_i) begin
    if (push_acc) mem[wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      if (pop_acc)  rd_ptr <= next_ptr(rd_ptr);
      if (push_acc) wr_ptr <= next_ptr(wr_ptr);

      if (push_acc && !pop_acc)      count <= count + cnt_w'(1);
      else if (pop_acc && !push_acc) count <= count - cnt_w'(1);

      if (push && !dest_ok && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (push && dest_ok && !push_acc)          ovf <= 1'b1;
      if (popin && count == '0)                  udf <= 1'b1;
    end
  end

  assign full          = (count == depth_c);
  assign pndng_i_in    = (count != '0);
  assign data_out_i_in = pndng_i_in ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_mesh_term_fifo.sv
// Directed bench for mesh_term_fifo with a queue scoreboard of expected head packets
// and a reference model of occupancy, flags and drop counter.
module tb_mesh_term_fifo;

  localparam int PSZ   = 40;
  localparam int DEPTH = 4;

  logic            clk_i = 1'b0;
  logic            reset;
  logic            push;
  logic [PSZ-1:0]  data_in;
  logic            full;
  logic [PSZ-1:0]  data_out_i_in;
  logic            pndng_i_in;
  logic            popin;
  logic [2:0]      count;
  logic [7:0]      drop_cnt;
  logic            ovf;
  logic            udf;

  mesh_term_fifo #(
    .pckg_sz(PSZ), .fifo_depth(DEPTH), .rows(4), .columns(4), .broadcast(8'hFF)
  ) dut (
    .clk_i(clk_i), .reset(reset), .push(push), .data_in(data_in), .full(full),
    .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in), .popin(popin),
    .count(count), .drop_cnt(drop_cnt), .ovf(ovf), .udf(udf)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [PSZ-1:0] sb [$];
  logic           m_ovf;
  logic           m_udf;
  int             m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PSZ-1:0] pkt(input logic [7:0] nj, input logic [3:0] r,
                                         input logic [3:0] c, input logic [22:0] pl);
    return {nj, r, c, 1'b0, pl};
  endfunction

  function automatic bit model_valid(input logic [PSZ-1:0] p);
    logic [7:0] nj;
    logic [3:0] r, c;
    nj = p[39:32];
    r  = p[31:28];
    c  = p[27:24];
    return (nj == 8'hFF) || (r < 4'd4 && c < 4'd4);
  endfunction

  task automatic check_all();
    logic [PSZ-1:0] head;
    head = (sb.size() != 0) ? sb[0] : '0;
    chk("count",    64'(count),         64'(sb.size()));
    chk("full",     64'(full),          64'(sb.size() == DEPTH));
    chk("pndng",    64'(pndng_i_in),    64'(sb.size() != 0));
    chk("head",     64'(data_out_i_in), 64'(head));
    chk("ovf",      64'(ovf),           64'(m_ovf));
    chk("udf",      64'(udf),           64'(m_udf));
    chk("drop_cnt", 64'(drop_cnt),      64'(m_drop));
  endtask

  // One clock cycle of stimulus; the model decides acceptance from pre-edge state.
  task automatic step(input bit p, input logic [PSZ-1:0] d, input bit pp);
    bit ok, pop_ok, push_ok;
    ok      = model_valid(d);
    pop_ok  = pp && (sb.size() != 0);
    push_ok = p && ok && (sb.size() < DEPTH || pop_ok);
    push    = p;
    data_in = d;
    popin   = pp;
    if (pop_ok) chk("pop_data", 64'(data_out_i_in), 64'(sb[0]));
    @(posedge clk_i);
    #1;
    if (pop_ok)            void'(sb.pop_front());
    if (push_ok)           sb.push_back(d);
    if (p && !ok && m_drop < 255) m_drop++;
    if (p && ok && !push_ok)      m_ovf = 1'b1;
    if (pp && !pop_ok)            m_udf = 1'b1;
    push  = 1'b0;
    popin = 1'b0;
    check_all();
  endtask

  task automatic model_reset();
    sb.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    check_all();
    reset = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  logic [PSZ-1:0] pa, pb, pc, pd, pe, bad_row, bad_col, bcast;

  initial begin
    push    = 1'b0;
    popin   = 1'b0;
    data_in = '0;
    reset   = 1'b0;
    model_reset();
    #3;
    check_all();
    reset = 1'b1;
    @(posedge clk_i);
    #1;

    // Single packet: write-to-head latency, then pop empties.
    pa = 40'h01_1_1_000001;
    step(1, pa, 0);
    step(0, '0, 0);
    step(0, '0, 1);

    // Fill, overflow, drain in order; ovf stays sticky.
    pa = pkt(8'h01, 4'd0, 4'd0, 23'h0000AA);
    pb = pkt(8'h02, 4'd1, 4'd2, 23'h0000BB);
    pc = pkt(8'h03, 4'd2, 4'd3, 23'h0000CC);
    pd = pkt(8'h04, 4'd3, 4'd3, 23'h0000DD);
    pe = pkt(8'h05, 4'd3, 4'd0, 23'h0000EE);
    step(1, pa, 0);
    step(1, pb, 0);
    step(1, pc, 0);
    step(1, pd, 0);
    step(1, pe, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 1);

    // Full with simultaneous push and pop; pointers wrap.
    do_reset();
    step(0, '0, 0);
    step(1, pa, 0);
    step(1, pb, 0);
    step(1, pc, 0);
    step(1, pd, 0);
    step(1, pe, 1);
    for (int i = 0; i < 4; i++) step(0, '0, 1);

    // Destination filter, broadcast bypass and drop counter saturation.
    bad_row = pkt(8'h01, 4'd4, 4'd0, 23'h1);
    bad_col = pkt(8'h01, 4'd0, 4'd5, 23'h2);
    bcast   = pkt(8'hFF, 4'd9, 4'd0, 23'h3);
    step(1, bad_row, 0);
    step(1, bad_col, 0);
    step(1, bcast, 0);
    step(0, '0, 1);
    for (int i = 0; i < 300; i++) step(1, (i % 2) ? bad_row : bad_col, 0);

    // Underflow, then push+pop at count 1 makes the new packet the head.
    step(0, '0, 1);
    step(0, '0, 1);
    step(1, pa, 0);
    step(1, pb, 1);
    step(0, '0, 1);

    // Asynchronous reset mid-cycle with 3 entries buffered.
    step(1, pc, 0);
    step(1, pd, 0);
    step(1, pe, 0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #2;
    reset = 1'b1;
    step(1, pa, 0);
    step(0, '0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
